regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Next-generation CORE register file: integer and FPU banks, NRP read ports, two writeback ports, and a per-register pending scoreboard.
- Write port 0 serves the in-order ALU/memory writeback. Write port 1 serves long-latency units (FPU divide/sqrt, cache-miss loads).
- Issue marks a destination register pending. The matching writeback clears it.
- Read ports return forwarded data and a per-port hazard flag. The ID stage uses these flags to stall.

Parameters:
- XLEN, 32, data width of every register.
- NREG, 32, registers per bank; address width AW = $clog2(NREG).
- NRP, 3, number of read ports.
- INT_ZERO_IDX, 0, integer register hardwired to zero.
- FP_ZERO_IDX, 30, FPU register hardwired to zero.
- DBG_IDX, 3, integer register mirrored on dbg_reg.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- rd_en  in  NRP  read port p is in use (qualifies its hazard flag).
- rd_fp  in  NRP  bank select for port p: 0 = integer, 1 = FPU.
- rd_addr  in  NRP*AW  register index for port p, packed.
- rd_data  out  NRP*XLEN  read data for port p, packed.
- rd_pending  out  NRP  port p's source register is awaiting a long-latency result.
- stall  out  1  OR over p of (rd_en[p] & rd_pending[p]).
- wb0_en  in  2  writeback port 0 bank: 00 none, 01 integer, 10 FPU, 11 none.
- wb0_addr  in  AW  writeback port 0 register index.
- wb0_data  in  XLEN  writeback port 0 data.
- wb1_en  in  2  writeback port 1 bank, same encoding as wb0_en.
- wb1_addr  in  AW  writeback port 1 register index.
- wb1_data  in  XLEN  writeback port 1 data.
- iss_en  in  2  mark a register pending, same bank encoding.
- iss_addr  in  AW  index of the register to mark pending.
- dbg_reg  out  XLEN  live copy of integer register DBG_IDX.

Behaviour:
- Reset: synchronous on the clk edge with rstn=0. All registers in both banks clear to 0 and all pending bits clear. After that edge: every rd_data = 0, rd_pending = 0, stall = 0, dbg_reg = 0. Reset overrides writes and issues in the same cycle, and also aborts any in-flight long-latency operation: a wb1 arriving after reset is an ordinary write with nothing to clear.
- Reads: combinational, zero latency. Priority per port:
  - Zero index (INT_ZERO_IDX in the integer bank, FP_ZERO_IDX in the FPU bank) reads 0.
  - Otherwise a same-cycle wb0 hit (same bank, same addr) returns wb0_data.
  - Otherwise a same-cycle wb1 hit returns wb1_data.
  - Otherwise the array content.
- Writes: on the clk edge. A write to the zero index of its bank is ignored.
  - wb0 and wb1 targeting the same bank and index: wb0 data is stored and wb1 data is dropped. wb0 is the younger in-order result.
  - Writes to different registers both commit.
- Scoreboard: one pending bit per register per bank.
  - Set at the edge when iss_en is valid. Issue to a zero index is ignored.
  - Cleared at the edge by a valid wb1 to the same bank/index, including the dropped-data collision case.
  - wb0 never clears pending bits.
  - Set and clear of the same bit in the same cycle: set wins (a new producer has been issued).
- rd_pending[p] = pending bit of the addressed register, AND NOT a same-cycle wb1 hit on it. A result arriving this cycle is forwarded, not stalled. A zero index never reports pending.
- Hazard flags are raw; the block has no handshake with the issuer. Issuing to an already-pending register keeps it pending. The issuer must not create WAW on long-latency targets.
- dbg_reg reflects array content only, with no forwarding.
- Enable encoding 11 is treated as no operation everywhere.

Decomposition:
- Shared package core_pkg holds:
  - the bank encodings BANK_NONE=2'b00, BANK_INT=2'b01, BANK_FP=2'b10;
  - XLEN and NREG defaults;
  - INT_ZERO_IDX and FP_ZERO_IDX.
- One sub-module, regfile_read_port: a single port's zero and forward mux plus its pending qualification. It is instantiated NRP times via generate. The array and scoreboard stay in the top module.

Test Plan:
- Reset then reads: write int x5 = 0xDEADBEEF, assert rstn=0 for one cycle, read x5 -> rd_data = 0, rd_pending = 0, dbg_reg = 0.
- Zero registers: wb0 int x0 = 0x1234 and wb0 fp f30 = 0x5678, then read both -> 0. In the same cycle as the write, also read both -> 0.
- Forwarding priority: same cycle wb0 int x7 = 0xA, wb1 int x7 = 0xB, read x7 -> 0xA; next cycle read x7 -> 0xA.
- Scoreboard: iss fp f4, next cycle read f4 with rd_en -> rd_pending = 1, stall = 1. Cycle wb1 fp f4 = 0x3F800000 -> rd_pending = 0, rd_data = 0x3F800000. Next cycle -> still 0x3F800000, not pending.
- Set-wins: pending int x9; same cycle wb1 int x9 = 0x1 and iss int x9 -> next cycle x9 pending, data 0x1.
- Bank isolation: wb0 int x3 = 0x11, wb0 fp f3 = 0x22 -> reads return int 0x11 and fp 0x22, dbg_reg = 0x11. Pending int x3 does not flag an fp f3 read.

Source files
------------

// File: rtl/core_pkg.sv
// Shared CORE constants: writeback/issue bank encodings and register-file defaults.
package core_pkg;

    localparam logic [1:0] BANK_NONE = 2'b00;
    localparam logic [1:0] BANK_INT  = 2'b01;
    localparam logic [1:0] BANK_FP   = 2'b10;

    localparam int unsigned CORE_XLEN         = 32;
    localparam int unsigned CORE_NREG         = 32;
    localparam int unsigned CORE_INT_ZERO_IDX = 0;
    localparam int unsigned CORE_FP_ZERO_IDX  = 30;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: zero-register override, same-cycle writeback forwarding
// and pending-flag qualification.
module regfile_read_port
    import core_pkg::*;
#(
    parameter int unsigned XLEN         = CORE_XLEN,
    parameter int unsigned AW           = 5,
    parameter int unsigned INT_ZERO_IDX = CORE_INT_ZERO_IDX,
    parameter int unsigned FP_ZERO_IDX  = CORE_FP_ZERO_IDX
) (
    input  logic            rd_fp_i,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [XLEN-1:0] arr_data_i,
    input  logic            arr_pend_i,
    input  logic [1:0]      wb0_en_i,
    input  logic [AW-1:0]   wb0_addr_i,
    input  logic [XLEN-1:0] wb0_data_i,
    input  logic [1:0]      wb1_en_i,
    input  logic [AW-1:0]   wb1_addr_i,
    input  logic [XLEN-1:0] wb1_data_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_pending_o
);

    localparam logic [AW-1:0] IntZero = AW'(INT_ZERO_IDX);
    localparam logic [AW-1:0] FpZero  = AW'(FP_ZERO_IDX);

    logic [1:0] bank;
    logic       is_zero;
    logic       wb0_hit;
    logic       wb1_hit;

    always_comb begin
        bank    = rd_fp_i ? BANK_FP : BANK_INT;
        is_zero = rd_fp_i ? (rd_addr_i == FpZero) : (rd_addr_i == IntZero);
        // Encodings 00/11 never equal a bank value, so they can never hit
        wb0_hit = (wb0_en_i == bank) && (wb0_addr_i == rd_addr_i);
        wb1_hit = (wb1_en_i == bank) && (wb1_addr_i == rd_addr_i);

        if (is_zero) begin
            rd_data_o = '0;
        end else if (wb0_hit) begin
            rd_data_o = wb0_data_i;
        end else if (wb1_hit) begin
            rd_data_o = wb1_data_i;
        end else begin
            rd_data_o = arr_data_i;
        end

        // A long-latency result landing this cycle is forwarded, so no hazard
        rd_pending_o = arr_pend_i & ~wb1_hit & ~is_zero;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer + FPU register file with two writeback ports, NRP forwarding read ports and a
// per-register pending scoreboard for long-latency producers.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned XLEN         = CORE_XLEN,
    parameter int unsigned NREG         = CORE_NREG,
    parameter int unsigned NRP          = 3,
    parameter int unsigned INT_ZERO_IDX = CORE_INT_ZERO_IDX,
    parameter int unsigned FP_ZERO_IDX  = CORE_FP_ZERO_IDX,
    parameter int unsigned DBG_IDX      = 3,
    localparam int unsigned AW          = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRP-1:0]      rd_en,
    input  logic [NRP-1:0]      rd_fp,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_pending,
    output logic                stall,
    input  logic [1:0]          wb0_en,
    input  logic [AW-1:0]       wb0_addr,
    input  logic [XLEN-1:0]     wb0_data,
    input  logic [1:0]          wb1_en,
    input  logic [AW-1:0]       wb1_addr,
    input  logic [XLEN-1:0]     wb1_data,
    input  logic [1:0]          iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [XLEN-1:0]     dbg_reg
);

    localparam logic [AW-1:0] IntZero = AW'(INT_ZERO_IDX);
    localparam logic [AW-1:0] FpZero  = AW'(FP_ZERO_IDX);
    localparam logic [AW-1:0] DbgAddr = AW'(DBG_IDX);

    logic [XLEN-1:0] int_q [NREG];
    logic [XLEN-1:0] int_d [NREG];
    logic [XLEN-1:0] fp_q  [NREG];
    logic [XLEN-1:0] fp_d  [NREG];
    logic [NREG-1:0] int_pend_q, int_pend_d;
    logic [NREG-1:0] fp_pend_q, fp_pend_d;

    always_comb begin
        int_d = int_q;
        fp_d  = fp_q;
        // wb1 applied first so a colliding wb0 (the younger result) overwrites it
        if (wb1_en == BANK_INT && wb1_addr != IntZero) int_d[wb1_addr] = wb1_data;
        if (wb1_en == BANK_FP  && wb1_addr != FpZero)  fp_d[wb1_addr]  = wb1_data;
        if (wb0_en == BANK_INT && wb0_addr != IntZero) int_d[wb0_addr] = wb0_data;
        if (wb0_en == BANK_FP  && wb0_addr != FpZero)  fp_d[wb0_addr]  = wb0_data;
    end

    always_comb begin
        int_pend_d = int_pend_q;
        fp_pend_d  = fp_pend_q;
        if (wb1_en == BANK_INT) int_pend_d[wb1_addr] = 1'b0;
        if (wb1_en == BANK_FP)  fp_pend_d[wb1_addr]  = 1'b0;
        // Issue after clear: a new producer outranks the retiring one
        if (iss_en == BANK_INT && iss_addr != IntZero) int_pend_d[iss_addr] = 1'b1;
        if (iss_en == BANK_FP  && iss_addr != FpZero)  fp_pend_d[iss_addr]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                int_q[i] <= '0;
                fp_q[i]  <= '0;
            end
            int_pend_q <= '0;
            fp_pend_q  <= '0;
        end else begin
            int_q      <= int_d;
            fp_q       <= fp_d;
            int_pend_q <= int_pend_d;
            fp_pend_q  <= fp_pend_d;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] arr_data;
        logic            arr_pend;

        assign addr     = rd_addr[p*AW +: AW];
        assign arr_data = rd_fp[p] ? fp_q[addr] : int_q[addr];
        assign arr_pend = rd_fp[p] ? fp_pend_q[addr] : int_pend_q[addr];

        regfile_read_port #(
            .XLEN         (XLEN),
            .AW           (AW),
            .INT_ZERO_IDX (INT_ZERO_IDX),
            .FP_ZERO_IDX  (FP_ZERO_IDX)
        ) u_rd_port (
            .rd_fp_i      (rd_fp[p]),
            .rd_addr_i    (addr),
            .arr_data_i   (arr_data),
            .arr_pend_i   (arr_pend),
            .wb0_en_i     (wb0_en),
            .wb0_addr_i   (wb0_addr),
            .wb0_data_i   (wb0_data),
            .wb1_en_i     (wb1_en),
            .wb1_addr_i   (wb1_addr),
            .wb1_data_i   (wb1_data),
            .rd_data_o    (rd_data[p*XLEN +: XLEN]),
            .rd_pending_o (rd_pending[p])
        );
    end

    always_comb begin
        stall = |(rd_en & rd_pending);
    end

    assign dbg_reg = int_q[DbgAddr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard: reset, zero registers, forwarding,
// scoreboard set/clear, bank isolation and no-op encodings.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NRP  = 3;
    localparam int unsigned AW   = 5;

    logic                clk;
    logic                rstn;
    logic [NRP-1:0]      rd_en;
    logic [NRP-1:0]      rd_fp;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_pending;
    logic                stall;
    logic [1:0]          wb0_en;
    logic [AW-1:0]       wb0_addr;
    logic [XLEN-1:0]     wb0_data;
    logic [1:0]          wb1_en;
    logic [AW-1:0]       wb1_addr;
    logic [XLEN-1:0]     wb1_data;
    logic [1:0]          iss_en;
    logic [AW-1:0]       iss_addr;
    logic [XLEN-1:0]     dbg_reg;

    int n_cmp = 0;
    int n_err = 0;

    regfile_scoreboard dut (
        .clk        (clk),
        .rstn       (rstn),
        .rd_en      (rd_en),
        .rd_fp      (rd_fp),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .stall      (stall),
        .wb0_en     (wb0_en),
        .wb0_addr   (wb0_addr),
        .wb0_data   (wb0_data),
        .wb1_en     (wb1_en),
        .wb1_addr   (wb1_addr),
        .wb1_data   (wb1_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .dbg_reg    (dbg_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_en   = '0;
        rd_fp   = '0;
        rd_addr = '0;
        wb0_en  = 2'b00; wb0_addr = '0; wb0_data = '0;
        wb1_en  = 2'b00; wb1_addr = '0; wb1_data = '0;
        iss_en  = 2'b00; iss_addr = '0;
    endtask

    task automatic rd(input int p, input logic en, input logic fp, input logic [AW-1:0] a);
        rd_en[p]           = en;
        rd_fp[p]           = fp;
        rd_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [31:0] dat(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    // Commit the current inputs, then leave the bench just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #1;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;

        // Reset state
        rd(0, 1'b1, 1'b0, 5'd5);
        settle();
        chk("reset_data", dat(0), 32'h0);
        chk("reset_pend", {31'b0, rd_pending[0]}, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_dbg", dbg_reg, 32'h0);

        // Write x5, then reset (with a write and issue also pending) clears it
        idle();
        wb0_en = 2'b01; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
        tick();
        idle();
        rd(0, 1'b1, 1'b0, 5'd5);
        settle();
        chk("x5_written", dat(0), 32'hDEADBEEF);
        rstn = 1'b0;
        wb0_en = 2'b01; wb0_addr = 5'd5; wb0_data = 32'h55;
        iss_en = 2'b01; iss_addr = 5'd5;
        tick();
        rstn = 1'b1;
        idle();
        rd(0, 1'b1, 1'b0, 5'd5);
        settle();
        chk("x5_after_rst", dat(0), 32'h0);
        chk("x5_pend_after_rst", {31'b0, rd_pending[0]}, 32'h0);
        chk("dbg_after_rst", dbg_reg, 32'h0);

        // Zero registers: write attempts and same-cycle reads
        idle();
        wb0_en = 2'b01; wb0_addr = 5'd0; wb0_data = 32'h1234;
        rd(0, 1'b1, 1'b0, 5'd0);
        settle();
        chk("x0_same_cycle", dat(0), 32'h0);
        tick();
        idle();
        wb0_en = 2'b10; wb0_addr = 5'd30; wb0_data = 32'h5678;
        iss_en = 2'b10; iss_addr = 5'd30;
        rd(1, 1'b1, 1'b1, 5'd30);
        settle();
        chk("f30_same_cycle", dat(1), 32'h0);
        tick();
        idle();
        rd(0, 1'b1, 1'b0, 5'd0);
        rd(1, 1'b1, 1'b1, 5'd30);
        settle();
        chk("x0_after", dat(0), 32'h0);
        chk("f30_after", dat(1), 32'h0);
        chk("f30_never_pend", {31'b0, rd_pending[1]}, 32'h0);

        // Forwarding priority and wb0-over-wb1 collision
        idle();
        wb0_en = 2'b01; wb0_addr = 5'd7; wb0_data = 32'hA;
        wb1_en = 2'b01; wb1_addr = 5'd7; wb1_data = 32'hB;
        rd(2, 1'b1, 1'b0, 5'd7);
        settle();
        chk("fwd_wb0_over_wb1", dat(2), 32'hA);
        tick();
        idle();
        rd(2, 1'b1, 1'b0, 5'd7);
        settle();
        chk("x7_stored_wb0", dat(2), 32'hA);
        wb1_en = 2'b01; wb1_addr = 5'd8; wb1_data = 32'hC;
        rd(0, 1'b1, 1'b0, 5'd8);
        settle();
        chk("fwd_wb1", dat(0), 32'hC);
        tick();
        idle();
        rd(0, 1'b1, 1'b0, 5'd8);
        settle();
        chk("x8_stored_wb1", dat(0), 32'hC);

        // Scoreboard: issue f4, stall, clear by wb1
        idle();
        iss_en = 2'b10; iss_addr = 5'd4;
        tick();
        idle();
        rd(0, 1'b1, 1'b1, 5'd4);
        rd(1, 1'b1, 1'b0, 5'd4);
        settle();
        chk("f4_pend", {31'b0, rd_pending[0]}, 32'h1);
        chk("f4_stall", {31'b0, stall}, 32'h1);
        chk("x4_not_pend", {31'b0, rd_pending[1]}, 32'h0);
        wb1_en = 2'b10; wb1_addr = 5'd4; wb1_data = 32'h3F800000;
        settle();
        chk("f4_wb1_pend", {31'b0, rd_pending[0]}, 32'h0);
        chk("f4_wb1_data", dat(0), 32'h3F800000);
        chk("f4_wb1_stall", {31'b0, stall}, 32'h0);
        tick();
        idle();
        rd(0, 1'b1, 1'b1, 5'd4);
        settle();
        chk("f4_next_data", dat(0), 32'h3F800000);
        chk("f4_next_pend", {31'b0, rd_pending[0]}, 32'h0);

        // wb0 does not clear pending; rd_en qualifies stall
        idle();
        iss_en = 2'b01; iss_addr = 5'd10;
        tick();
        idle();
        wb0_en = 2'b01; wb0_addr = 5'd10; wb0_data = 32'h77;
        rd(0, 1'b1, 1'b0, 5'd10);
        settle();
        chk("x10_wb0_fwd", dat(0), 32'h77);
        chk("x10_wb0_pend", {31'b0, rd_pending[0]}, 32'h1);
        tick();
        idle();
        rd(0, 1'b1, 1'b0, 5'd10);
        settle();
        chk("x10_still_pend", {31'b0, rd_pending[0]}, 32'h1);
        chk("x10_stall", {31'b0, stall}, 32'h1);
        rd(0, 1'b0, 1'b0, 5'd10);
        settle();
        chk("x10_no_en_stall", {31'b0, stall}, 32'h0);
        chk("x10_no_en_pend", {31'b0, rd_pending[0]}, 32'h1);

        // Set wins over clear
        idle();
        iss_en = 2'b01; iss_addr = 5'd9;
        tick();
        idle();
        wb1_en = 2'b01; wb1_addr = 5'd9; wb1_data = 32'h1;
        iss_en = 2'b01; iss_addr = 5'd9;
        rd(1, 1'b1, 1'b0, 5'd9);
        settle();
        chk("x9_fwd", dat(1), 32'h1);
        chk("x9_fwd_pend", {31'b0, rd_pending[1]}, 32'h0);
        tick();
        idle();
        rd(1, 1'b1, 1'b0, 5'd9);
        settle();
        chk("x9_set_wins", {31'b0, rd_pending[1]}, 32'h1);
        chk("x9_data", dat(1), 32'h1);

        // Collision still clears pending
        idle();
        iss_en = 2'b01; iss_addr = 5'd11;
        tick();
        idle();
        wb0_en = 2'b01; wb0_addr = 5'd11; wb0_data = 32'hAA;
        wb1_en = 2'b01; wb1_addr = 5'd11; wb1_data = 32'hBB;
        tick();
        idle();
        rd(0, 1'b1, 1'b0, 5'd11);
        settle();
        chk("x11_data", dat(0), 32'hAA);
        chk("x11_cleared", {31'b0, rd_pending[0]}, 32'h0);

        // Bank isolation and dbg_reg
        idle();
        wb0_en = 2'b01; wb0_addr = 5'd3; wb0_data = 32'h11;
        tick();
        idle();
        wb0_en = 2'b10; wb0_addr = 5'd3; wb0_data = 32'h22;
        tick();
        idle();
        rd(0, 1'b1, 1'b0, 5'd3);
        rd(1, 1'b1, 1'b1, 5'd3);
        settle();
        chk("int_x3", dat(0), 32'h11);
        chk("fp_f3", dat(1), 32'h22);
        chk("dbg_x3", dbg_reg, 32'h11);
        iss_en = 2'b01; iss_addr = 5'd3;
        tick();
        idle();
        rd(0, 1'b0, 1'b0, 5'd3);
        rd(1, 1'b1, 1'b1, 5'd3);
        wb0_en = 2'b01; wb0_addr = 5'd3; wb0_data = 32'h33;
        settle();
        chk("f3_not_pend", {31'b0, rd_pending[1]}, 32'h0);
        chk("f3_no_stall", {31'b0, stall}, 32'h0);
        chk("x3_pend", {31'b0, rd_pending[0]}, 32'h1);
        chk("dbg_no_fwd", dbg_reg, 32'h11);
        tick();
        idle();
        settle();
        chk("dbg_updated", dbg_reg, 32'h33);

        // Encoding 11 is a no-op
        idle();
        wb0_en = 2'b11; wb0_addr = 5'd12; wb0_data = 32'hFF;
        wb1_en = 2'b11; wb1_addr = 5'd12; wb1_data = 32'hEE;
        iss_en = 2'b11; iss_addr = 5'd12;
        rd(2, 1'b1, 1'b0, 5'd12);
        settle();
        chk("enc11_no_fwd", dat(2), 32'h0);
        tick();
        idle();
        rd(2, 1'b1, 1'b0, 5'd12);
        rd(0, 1'b1, 1'b1, 5'd12);
        settle();
        chk("enc11_no_write", dat(2), 32'h0);
        chk("enc11_no_pend", {31'b0, rd_pending[2]}, 32'h0);
        chk("enc11_fp_no_write", dat(0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
